// File: rtl/bp_sac_wh_arbiter_pkg.sv
// bp_sac_wh_arbiter_pkg
//   Shared SAC coherence-NoC definitions: wormhole arbiter state encoding and
//   the header layout helper. A header flit carries the destination coordinate
//   in bits [cord_width-1:0] and the body-flit count ("len") immediately above
//   it, in bits [cord_width +: len_width].
package bp_sac_wh_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    // Header fields must lie within this many low-order bits of a flit.
    localparam int unsigned hdr_span_max_lp = 64;

    // Extract the len field of a header flit (zero-extended to 32 bits).
    function automatic logic [31:0] hdr_len_f(
        input logic [hdr_span_max_lp-1:0] flit,
        input int unsigned                cord_width,
        input int unsigned                len_width
    );
        logic [hdr_span_max_lp-1:0] shifted;
        shifted = flit >> cord_width;
        return shifted[31:0] & ((32'd1 << len_width) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sac_wh_arbiter_rr_pick.sv
// bp_sac_rr_pick
//   Combinational round-robin priority encoder. The search begins one past
//   the last-served requester and wraps modulo num_req_p.
//   Ports:
//     req  - request vector
//     last - index of the requester served most recently
//     gnt  - one-hot winner (zero when no request)
//     idx  - binary index of the winner (zero when no request)
//     any  - at least one request present
module bp_sac_rr_pick #(
    parameter int unsigned num_req_p = 4
) (
    input  logic [num_req_p-1:0]         req,
    input  logic [$clog2(num_req_p)-1:0] last,
    output logic [num_req_p-1:0]         gnt,
    output logic [$clog2(num_req_p)-1:0] idx,
    output logic                         any
);
    localparam int unsigned id_width_lp = $clog2(num_req_p);

    logic [id_width_lp-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 1; i <= num_req_p; i++) begin
            cand = id_width_lp'((32'(last) + i) % num_req_p);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/bp_sac_wh_arbiter.sv
// bp_sac_wh_arbiter
//   Round-robin wormhole arbiter merging num_req_p flit streams onto one
//   ready-and link. A granted header holds the link until the packet's final
//   flit, so packets never interleave.
//   Ports:
//     clk_i, reset_i - clock, asynchronous active-high reset
//     v_i, data_i    - per-requester flit valid / flit (flattened)
//     ready_and_o    - per-requester ready (only the connected requester)
//     v_o, data_o    - merged flit valid / flit
//     ready_and_i    - downstream ready
//     grant_o        - one-hot connected requester, zero when none
//     pkt_done_o     - pulse when a packet's final flit is accepted
module bp_sac_wh_arbiter
    import bp_sac_wh_arbiter_pkg::*;
#(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned cord_width_p = 8,
    parameter int unsigned len_width_p  = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p*flit_width_p-1:0] data_i,
    output logic [num_req_p-1:0]              ready_and_o,
    output logic                              v_o,
    output logic [flit_width_p-1:0]           data_o,
    input  logic                              ready_and_i,
    output logic [num_req_p-1:0]              grant_o,
    output logic                              pkt_done_o
);
    localparam int unsigned id_width_lp = $clog2(num_req_p);

    arb_state_e             state_q, state_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic [id_width_lp-1:0] gnt_q, gnt_d;
    logic [id_width_lp-1:0] last_q, last_d;

    logic [num_req_p-1:0][flit_width_p-1:0] data_arr;
    logic [num_req_p-1:0]   pick_gnt;
    logic [id_width_lp-1:0] pick_idx;
    logic                   pick_any;
    logic [id_width_lp-1:0] sel_idx;
    logic [flit_width_p-1:0] sel_data;
    logic [len_width_p-1:0] hdr_len;
    logic                   hs;

    assign data_arr = data_i;

    bp_sac_rr_pick #(
        .num_req_p(num_req_p)
    ) u_pick (
        .req (v_i),
        .last(last_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        grant_o     = '0;
        v_o         = 1'b0;
        ready_and_o = '0;
        pkt_done_o  = 1'b0;
        hs          = 1'b0;

        sel_idx  = (state_q == ARB_BUSY) ? gnt_q : pick_idx;
        sel_data = data_arr[sel_idx];
        data_o   = sel_data;
        hdr_len  = len_width_p'(hdr_len_f(hdr_span_max_lp'(sel_data),
                                          cord_width_p, len_width_p));

        if (state_q == ARB_BUSY) begin
            // The owner stays connected even while it withholds v_i.
            grant_o[gnt_q] = 1'b1;
            v_o            = v_i[gnt_q];
        end else begin
            grant_o = pick_gnt;
            v_o     = pick_any;
        end

        // Outputs are silenced throughout reset, including the comb paths.
        if (reset_i) begin
            grant_o = '0;
            v_o     = 1'b0;
        end

        ready_and_o = grant_o & {num_req_p{ready_and_i}};
        hs          = v_o & ready_and_i;

        if (hs) begin
            if (state_q == ARB_IDLE) begin
                if (hdr_len == '0) begin
                    pkt_done_o = 1'b1;
                    last_d     = pick_idx;
                end else begin
                    gnt_d   = pick_idx;
                    cnt_d   = hdr_len;
                    state_d = ARB_BUSY;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == len_width_p'(1)) begin
                    pkt_done_o = 1'b1;
                    last_d     = gnt_q;
                    state_d    = ARB_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            last_q  <= id_width_lp'(num_req_p - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

endmodule
